// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared core widths and global-history checkpoint types
//   GH_LENGTH            global history width consumed by gbpt_index_hash
//   GH_CKPT_ENTRIES      checkpoint slots (power of two, >= 2)
//   LOG_GH_CKPT_ENTRIES  checkpoint index width
//   gh_ckpt_idx_t        checkpoint slot index
//   gh_ckpt_ptr_t        checkpoint pointer: slot index plus wrap bit in the MSB
//   gh_shift()           shift one branch direction into a history value (LSB = newest)
package core_types_pkg;

    localparam int GH_LENGTH           = 12;
    localparam int GH_CKPT_ENTRIES     = 8;
    localparam int LOG_GH_CKPT_ENTRIES = $clog2(GH_CKPT_ENTRIES);

    typedef logic [GH_LENGTH-1:0]         gh_t;
    typedef logic [LOG_GH_CKPT_ENTRIES-1:0] gh_ckpt_idx_t;
    typedef logic [LOG_GH_CKPT_ENTRIES:0]   gh_ckpt_ptr_t;

    function automatic gh_t gh_shift(input gh_t gh, input logic taken);
        return {gh[GH_LENGTH-2:0], taken};
    endfunction

endpackage

// File: rtl/gbpt_gh_manager.sv
// rtl/gbpt_gh_manager.sv - speculative global history with checkpoint/restore ring
//   CLK                   clock, rising edge
//   nRST                  synchronous reset, active-low
//   spec_update_valid     predicted conditional branch this cycle
//   spec_update_taken     predicted direction
//   spec_update_ready     ring not full and no restore this cycle
//   spec_update_ckpt_idx  slot the current update allocates (tail index)
//   restore_valid         mispredict of a checkpointed branch
//   restore_ckpt_idx      checkpoint slot of the mispredicted branch
//   restore_taken         actual direction of the mispredicted branch
//   commit_valid          oldest checkpointed branch retired
//   GH                    current speculative global history (to gbpt_index_hash)
//   ckpt_empty            no live checkpoints
//   ckpt_full             every slot holds a live checkpoint
module gbpt_gh_manager
    import core_types_pkg::*;
(
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           spec_update_valid,
    input  logic                           spec_update_taken,
    output logic                           spec_update_ready,
    output logic [LOG_GH_CKPT_ENTRIES-1:0] spec_update_ckpt_idx,
    input  logic                           restore_valid,
    input  logic [LOG_GH_CKPT_ENTRIES-1:0] restore_ckpt_idx,
    input  logic                           restore_taken,
    input  logic                           commit_valid,
    output logic [GH_LENGTH-1:0]           GH,
    output logic                           ckpt_empty,
    output logic                           ckpt_full
);

    localparam int IW = LOG_GH_CKPT_ENTRIES;

    gh_t          gh_q;
    gh_ckpt_ptr_t head_q;
    gh_ckpt_ptr_t tail_q;
    // Checkpoint storage is deliberately not reset; a slot is only read once written.
    gh_t          ckpt_q [GH_CKPT_ENTRIES];

    logic         update_fire;
    logic         commit_fire;
    gh_ckpt_idx_t restore_offset;
    gh_ckpt_ptr_t restore_tail;
    gh_t          restore_src;

    assign GH                   = gh_q;
    assign ckpt_empty           = (head_q == tail_q);
    assign ckpt_full            = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
    assign spec_update_ready    = !ckpt_full && !restore_valid;
    assign spec_update_ckpt_idx = tail_q[IW-1:0];

    assign update_fire = spec_update_valid && spec_update_ready;
    // A commit with nothing live would move head past tail; it is ignored.
    assign commit_fire = commit_valid && !ckpt_empty;

    // The restored slot's distance from head picks the wrap bit: head plus that
    // distance is the live pointer to the slot, so the new tail lands one past it
    // on the correct lap even when the ring has wrapped.
    assign restore_offset = restore_ckpt_idx - head_q[IW-1:0];
    assign restore_tail   = head_q + {1'b0, restore_offset} + gh_ckpt_ptr_t'(1);
    assign restore_src    = ckpt_q[restore_ckpt_idx];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            gh_q   <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            // update_fire is already blocked by restore_valid through ready.
            if (restore_valid) begin
                gh_q   <= gh_shift(restore_src, restore_taken);
                tail_q <= restore_tail;
            end else if (update_fire) begin
                gh_q   <= gh_shift(gh_q, spec_update_taken);
                tail_q <= tail_q + gh_ckpt_ptr_t'(1);
            end
            if (commit_fire) begin
                head_q <= head_q + gh_ckpt_ptr_t'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && update_fire) begin
            ckpt_q[tail_q[IW-1:0]] <= gh_q;
        end
    end

endmodule

// File: tb/tb_gbpt_gh_manager.sv
// tb/tb_gbpt_gh_manager.sv - directed vector bench for gbpt_gh_manager
module tb_gbpt_gh_manager;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        spec_update_valid = 1'b0;
    logic        spec_update_taken = 1'b0;
    logic        spec_update_ready;
    logic [2:0]  spec_update_ckpt_idx;
    logic        restore_valid = 1'b0;
    logic [2:0]  restore_ckpt_idx = 3'd0;
    logic        restore_taken = 1'b0;
    logic        commit_valid = 1'b0;
    logic [11:0] GH;
    logic        ckpt_empty;
    logic        ckpt_full;

    int total = 0;
    int bad   = 0;

    gbpt_gh_manager dut (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .spec_update_valid    (spec_update_valid),
        .spec_update_taken    (spec_update_taken),
        .spec_update_ready    (spec_update_ready),
        .spec_update_ckpt_idx (spec_update_ckpt_idx),
        .restore_valid        (restore_valid),
        .restore_ckpt_idx     (restore_ckpt_idx),
        .restore_taken        (restore_taken),
        .commit_valid         (commit_valid),
        .GH                   (GH),
        .ckpt_empty           (ckpt_empty),
        .ckpt_full            (ckpt_full)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (nRST && commit_valid) begin
            assert (!ckpt_empty) else $error("illegal commit while empty");
        end
    end

    typedef struct {
        logic        rst;
        logic        su;
        logic        st;
        logic        rv;
        logic [2:0]  ri;
        logic        rt;
        logic        cm;
        logic [11:0] gh;
        logic [2:0]  idx;
        logic        emp;
        logic        ful;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic su, input logic st, input logic rv,
                       input logic [2:0] ri, input logic rt, input logic cm,
                       input logic [11:0] gh, input logic [2:0] idx,
                       input logic emp, input logic ful, input logic rdy);
        vec_t v;
        v.rst = rst; v.su = su; v.st = st; v.rv = rv; v.ri = ri; v.rt = rt; v.cm = cm;
        v.gh = gh; v.idx = idx; v.emp = emp; v.ful = ful; v.rdy = rdy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, n, act, exp);
        end
    endtask

    task automatic idle();
        nRST = 1'b1;
        spec_update_valid = 1'b0;
        spec_update_taken = 1'b0;
        restore_valid = 1'b0;
        restore_ckpt_idx = 3'd0;
        restore_taken = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic check_state(input string tag, input int n, input logic [11:0] gh,
                               input logic [2:0] idx, input logic emp, input logic ful, input logic rdy);
        chk({tag, "_gh"},    n, 32'(GH), 32'(gh));
        chk({tag, "_idx"},   n, 32'(spec_update_ckpt_idx), 32'(idx));
        chk({tag, "_empty"}, n, 32'(ckpt_empty), 32'(emp));
        chk({tag, "_full"},  n, 32'(ckpt_full), 32'(ful));
        chk({tag, "_ready"}, n, 32'(spec_update_ready), 32'(rdy));
    endtask

    task automatic step_update(input logic taken);
        @(negedge CLK);
        idle();
        spec_update_valid = 1'b1;
        spec_update_taken = taken;
        @(posedge CLK);
        #1 idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset then T,N,T,T
        add(1,0,0,0,0,0,0, 12'h000, 3'd0, 1,0,1);
        add(0,1,1,0,0,0,0, 12'h001, 3'd1, 0,0,1);
        add(0,1,0,0,0,0,0, 12'h002, 3'd2, 0,0,1);
        add(0,1,1,0,0,0,0, 12'h005, 3'd3, 0,0,1);
        add(0,1,1,0,0,0,0, 12'h00B, 3'd4, 0,0,1);
        // 2: fill from reset, drop the 9th, one commit reopens
        add(1,0,0,0,0,0,0, 12'h000, 3'd0, 1,0,1);
        for (int k = 1; k <= 8; k++)
            add(0,1,1,0,0,0,0, 12'((1 << k) - 1), 3'(k % 8), 0, k == 8, k != 8);
        add(0,1,0,0,0,0,0, 12'h0FF, 3'd0, 0,1,0);
        add(0,0,0,0,0,0,1, 12'h0FF, 3'd0, 0,0,1);
        // 4: drain to empty on the second lap, 3 updates, restore slot 1, refill to full
        for (int k = 1; k <= 7; k++)
            add(0,0,0,0,0,0,1, 12'h0FF, 3'd0, k == 7, 0, 1);
        add(0,1,1,0,0,0,0, 12'h1FF, 3'd1, 0,0,1);
        add(0,1,0,0,0,0,0, 12'h3FE, 3'd2, 0,0,1);
        add(0,1,1,0,0,0,0, 12'h7FD, 3'd3, 0,0,1);
        add(0,0,0,1,3'd1,1,0, 12'h3FF, 3'd2, 0,0,1);
        for (int j = 1; j <= 6; j++)
            add(0,1,0,0,0,0,0, 12'(12'h3FF << j), 3'((2 + j) % 8), 0, j == 6, j != 6);
        // 3: T,T,T then restore slot 1 not-taken
        add(1,0,0,0,0,0,0, 12'h000, 3'd0, 1,0,1);
        add(0,1,1,0,0,0,0, 12'h001, 3'd1, 0,0,1);
        add(0,1,1,0,0,0,0, 12'h003, 3'd2, 0,0,1);
        add(0,1,1,0,0,0,0, 12'h007, 3'd3, 0,0,1);
        add(0,0,0,1,3'd1,0,0, 12'h002, 3'd2, 0,0,1);
        // 5: commit + restore of the head slot empties the ring
        add(0,0,0,1,3'd0,1,1, 12'h001, 3'd1, 1,0,1);
        // 6: five live checkpoints then reset with other inputs active
        for (int k = 1; k <= 5; k++)
            add(0,1,1,0,0,0,0, 12'((1 << (k + 1)) - 1), 3'(1 + k), 0,0,1);
        add(1,1,1,0,0,0,1, 12'h000, 3'd0, 1,0,1);

        idle();
        nRST = 1'b0;
        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge CLK);
            nRST              = !vecs[n].rst;
            spec_update_valid = vecs[n].su;
            spec_update_taken = vecs[n].st;
            restore_valid     = vecs[n].rv;
            restore_ckpt_idx  = vecs[n].ri;
            restore_taken     = vecs[n].rt;
            commit_valid      = vecs[n].cm;
            @(posedge CLK);
            #1 idle();
            #1 check_state("vec", n, vecs[n].gh, vecs[n].idx, vecs[n].emp, vecs[n].ful, vecs[n].rdy);
        end

        // Restore and update in the same cycle: ready drops, update is lost.
        @(negedge CLK);
        idle();
        nRST = 1'b0;
        @(posedge CLK);
        #1 idle();
        step_update(1'b1);
        step_update(1'b1);
        #1 check_state("pre_sim", 0, 12'h003, 3'd2, 0, 0, 1);
        @(negedge CLK);
        spec_update_valid = 1'b1;
        spec_update_taken = 1'b1;
        restore_valid     = 1'b1;
        restore_ckpt_idx  = 3'd1;
        restore_taken     = 1'b0;
        #1 chk("sim_ready_comb", 0, 32'(spec_update_ready), 32'd0);
        @(posedge CLK);
        #1 idle();
        #1 check_state("sim_after", 0, 12'h002, 3'd2, 0, 0, 1);

        // Commit and update together: both apply.
        @(negedge CLK);
        spec_update_valid = 1'b1;
        spec_update_taken = 1'b1;
        commit_valid      = 1'b1;
        @(posedge CLK);
        #1 idle();
        #1 check_state("cm_up", 0, 12'h005, 3'd3, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            commit_valid = 1'b1;
            @(posedge CLK);
            #1 idle();
        end
        #1 check_state("drain", 0, 12'h005, 3'd3, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
